knn_vote: RTL and testbench

Majority-vote classifier that sits directly downstream of the KNN distance/sort cores. It captures the packed neighbour-label vector produced for one test point and counts votes per class over the valid neighbours. It then scans the counters and reports the winning class, its vote count and a tie flag with a one-cycle done pulse. One instance serves one test point; the peripheral instantiates one per test point or time-shares one.

---
 rtl/knn_vote.sv | 203 ++++++++++++++++++++
 tb/tb_knn_vote.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
//  Module      : knn_vote
//  Description : Majority-vote classifier for one KNN test point. Snapshots
//                the packed neighbour-label vector on start, counts one slot
//                per cycle into per-class vote counters, then scans the
//                counters one class per cycle to find the winner.
//  Ports       : clk            - system clock, rising edge
//                rst            - asynchronous active-low reset
//                start          - vote request, sampled only when idle
//                neighbour_info - packed labels, slot 0 (nearest) in LSBs
//                n_valid        - number of populated slots (saturates)
//                busy           - vote in progress
//                done           - one-cycle pulse when results update
//                class_out      - winning class index
//                votes_out      - vote count of the winning class
//                tie            - another class shares the nonzero maximum
//                bad_label      - a counted slot held a label >= N_CLASSES
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_vote #(
  parameter  int LABEL       = 8,
  parameter  int N_NEIGHBOUR = 10,
  parameter  int N_CLASSES   = 10,
  localparam int CNT_W       = $clog2(N_NEIGHBOUR + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_NEIGHBOUR*LABEL-1:0] neighbour_info,
  input  logic [CNT_W-1:0]             n_valid,
  output logic                         busy,
  output logic                         done,
  output logic [LABEL-1:0]             class_out,
  output logic [CNT_W-1:0]             votes_out,
  output logic                         tie,
  output logic                         bad_label
);

  localparam int CIDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [CIDX_W-1:0] C_LAST_CLASS = CIDX_W'(N_CLASSES - 1);
  localparam logic [LABEL:0]    C_NCLS       = (LABEL + 1)'(N_CLASSES);
  localparam logic [CNT_W-1:0]  C_NMAX       = CNT_W'(N_NEIGHBOUR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [N_NEIGHBOUR*LABEL-1:0] info_q, info_d;
  logic [CNT_W-1:0]             nsnap_q, nsnap_d;
  logic [CNT_W-1:0]             slot_q, slot_d;
  logic [CIDX_W-1:0]            cls_q, cls_d;
  logic [CNT_W-1:0]             cnt_q [N_CLASSES];
  logic [CNT_W-1:0]             cnt_d [N_CLASSES];
  logic [CNT_W-1:0]             max_q, max_d;
  logic [CIDX_W-1:0]            arg_q, arg_d;
  logic                         tacc_q, tacc_d;
  logic                         bacc_q, bacc_d;
  logic [LABEL-1:0]             class_q, class_d;
  logic [CNT_W-1:0]             votes_q, votes_d;
  logic                         tie_q, tie_d;
  logic                         bad_q, bad_d;

  logic [LABEL-1:0]             slot_lbl [N_NEIGHBOUR];
  logic [LABEL-1:0]             cur_lbl;
  logic [CNT_W-1:0]             cur_cnt;

  for (genvar k = 0; k < N_NEIGHBOUR; k++) begin : g_unpack
    assign slot_lbl[k] = info_q[k*LABEL +: LABEL];
  end

  assign cur_lbl = slot_lbl[slot_q];
  assign cur_cnt = cnt_q[cls_q];

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = (nsnap_q == '0) ? S_SCAN : S_COUNT;
      S_COUNT: if (slot_q == nsnap_q - CNT_W'(1)) state_d = S_SCAN;
      S_SCAN:  if (cls_q == C_LAST_CLASS) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs from state ----------------
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    info_d  = info_q;
    nsnap_d = nsnap_q;
    slot_d  = slot_q;
    cls_d   = cls_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    arg_d   = arg_q;
    tacc_d  = tacc_q;
    bacc_d  = bacc_q;
    class_d = class_q;
    votes_d = votes_q;
    tie_d   = tie_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          info_d  = neighbour_info;
          nsnap_d = (n_valid > C_NMAX) ? C_NMAX : n_valid;
        end
      end
      S_CLEAR: begin
        for (int c = 0; c < N_CLASSES; c++) cnt_d[c] = '0;
        slot_d = '0;
        cls_d  = '0;
        max_d  = '0;
        arg_d  = '0;
        tacc_d = 1'b0;
        bacc_d = 1'b0;
      end
      S_COUNT: begin
        if ({1'b0, cur_lbl} < C_NCLS)
          cnt_d[cur_lbl[CIDX_W-1:0]] = cnt_q[cur_lbl[CIDX_W-1:0]] + CNT_W'(1);
        else
          bacc_d = 1'b1;
        slot_d = slot_q + CNT_W'(1);
      end
      S_SCAN: begin
        // Strict greater-than keeps the lowest index on equal counts.
        if (cur_cnt > max_q) begin
          max_d  = cur_cnt;
          arg_d  = cls_q;
          tacc_d = 1'b0;
        end else if ((cur_cnt == max_q) && (max_q != '0)) begin
          tacc_d = 1'b1;
        end
        cls_d = cls_q + CIDX_W'(1);
        // Results are loaded on the edge entering DONE, so they must include
        // the final class comparison made in this same cycle.
        if (cls_q == C_LAST_CLASS) begin
          class_d = LABEL'(arg_d);
          votes_d = max_d;
          tie_d   = tacc_d;
          bad_d   = bacc_q;
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      info_q  <= '0;
      nsnap_q <= '0;
      slot_q  <= '0;
      cls_q   <= '0;
      for (int c = 0; c < N_CLASSES; c++) cnt_q[c] <= '0;
      max_q   <= '0;
      arg_q   <= '0;
      tacc_q  <= 1'b0;
      bacc_q  <= 1'b0;
      class_q <= '0;
      votes_q <= '0;
      tie_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      info_q  <= info_d;
      nsnap_q <= nsnap_d;
      slot_q  <= slot_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
      tacc_q  <= tacc_d;
      bacc_q  <= bacc_d;
      class_q <= class_d;
      votes_q <= votes_d;
      tie_q   <= tie_d;
      bad_q   <= bad_d;
    end
  end

  assign class_out = class_q;
  assign votes_out = votes_q;
  assign tie       = tie_q;
  assign bad_label = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
//  Module      : tb_knn_vote
//  Description : Scoreboard bench for knn_vote. Stimulus pushes the expected
//                result of each accepted vote; a monitor pops and compares on
//                every done pulse, including the start-to-done latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_vote;

  localparam int LABEL = 8;
  localparam int NN    = 10;
  localparam int NC    = 10;
  localparam int CW    = $clog2(NN + 1);

  logic              clk;
  logic              rst;
  logic              start;
  logic [NN*LABEL-1:0] neighbour_info;
  logic [CW-1:0]     n_valid;
  logic              busy;
  logic              done;
  logic [LABEL-1:0]  class_out;
  logic [CW-1:0]     votes_out;
  logic              tie;
  logic              bad_label;

  knn_vote #(.LABEL(LABEL), .N_NEIGHBOUR(NN), .N_CLASSES(NC)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .neighbour_info (neighbour_info),
    .n_valid        (n_valid),
    .busy           (busy),
    .done           (done),
    .class_out      (class_out),
    .votes_out      (votes_out),
    .tie            (tie),
    .bad_label      (bad_label)
  );

  typedef struct {
    int cls;
    int votes;
    int tie;
    int bad;
    int lat;
    int start_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("class_out", int'(class_out), e.cls);
        check("votes_out", int'(votes_out), e.votes);
        check("tie",       int'(tie),       e.tie);
        check("bad_label", int'(bad_label), e.bad);
        check("latency",   cyc - e.start_cyc + 1, e.lat);
      end
    end
  end

  function automatic logic [NN*LABEL-1:0] pack(input int l [NN]);
    logic [NN*LABEL-1:0] p;
    for (int k = 0; k < NN; k++) p[k*LABEL +: LABEL] = l[k][LABEL-1:0];
    return p;
  endfunction

  // Issue one vote and wait (bounded) for its done. With glitch set, new
  // labels plus a start pulse are driven in cycle 5, and start is held high
  // in the done cycle; neither may be accepted.
  task automatic run(input int l [NN], input int nv, input int ecls,
                     input int evotes, input int etie, input int ebad,
                     input bit glitch);
    exp_t e;
    int   lat, nb, d0;
    bit   seen;
    int   junk [NN];
    for (int k = 0; k < NN; k++) junk[k] = 9;
    lat = 2 + ((nv > NN) ? NN : nv) + NC;
    @(negedge clk);
    neighbour_info = pack(l);
    n_valid        = CW'(nv);
    start          = 1'b1;
    @(posedge clk);
    #1;
    e.cls = ecls; e.votes = evotes; e.tie = etie; e.bad = ebad;
    e.lat = lat;  e.start_cyc = cyc;
    sb.push_back(e);
    d0   = done_cnt;
    nb   = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) nb++;
      if (glitch && i == 5) begin
        neighbour_info = pack(junk);
        n_valid        = CW'(3);
        start          = 1'b1;
      end else if (glitch && i == 6) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        if (glitch) start = 1'b1;
      end
    end
    check("done_seen", int'(seen), 1);
    check("busy_cycles", nb, lat);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", int'(busy), 0);
    if (glitch) begin
      repeat (30) @(negedge clk);
      check("done_pulses", done_cnt - d0, 1);
      check("busy_idle", int'(busy), 0);
    end
  endtask

  initial begin
    int t1 [NN] = '{3, 3, 3, 1, 1, 2, 2, 2, 2, 0};
    int t2 [NN] = '{5, 5, 7, 7, 0, 0, 0, 0, 0, 0};
    int t3 [NN] = '{9, 9, 1, 4, 4, 4, 2, 8, 8, 3};
    int t4 [NN] = '{12, 12, 12, 4, 0, 0, 0, 0, 0, 0};
    int t5 [NN] = '{1, 12, 12, 12, 12, 12, 12, 12, 12, 12};
    int t6 [NN] = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
    int d0;

    rst            = 1'b0;
    start          = 1'b0;
    neighbour_info = '0;
    n_valid        = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(busy),      0);
    check("rst_done",  int'(done),      0);
    check("rst_class", int'(class_out), 0);
    check("rst_votes", int'(votes_out), 0);
    check("rst_tie",   int'(tie),       0);
    check("rst_bad",   int'(bad_label), 0);
    rst = 1'b1;

    run(t1, 10, 2, 4, 0, 0, 1'b0);   // clear winner
    run(t2, 4,  5, 2, 1, 0, 1'b0);   // tie resolves to lowest index
    run(t3, 0,  0, 0, 0, 0, 1'b0);   // empty vote
    run(t4, 4,  4, 1, 0, 1, 1'b0);   // out-of-range labels flagged
    run(t5, 1,  1, 1, 0, 0, 1'b0);   // bad labels beyond n_valid ignored
    run(t1, 10, 2, 4, 0, 0, 1'b1);   // input changes/starts while busy

    // Abort a vote with reset in cycle 8.
    d0 = done_cnt;
    @(negedge clk);
    neighbour_info = pack(t2);
    n_valid        = CW'(4);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy",  int'(busy),      0);
    check("abort_done",  int'(done),      0);
    check("abort_class", int'(class_out), 0);
    check("abort_votes", int'(votes_out), 0);
    check("abort_tie",   int'(tie),       0);
    check("abort_bad",   int'(bad_label), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    run(t6, 15, 6, 10, 0, 0, 1'b0);  // n_valid saturates to 10

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
